// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the ST7920 12864 LCD bus arbiter:
//   - lcd_state_e   : write-cycle FSM state encoding
//   - CMD_*         : common ST7920 command bytes
//   - DEF_*         : default write timing for a 50MHz clock
//   - is_clear_cmd  : identifies the display-clear command (needs the long wait)
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_BASIC   = 8'h30;
  localparam logic [7:0] CMD_EXT_GFX = 8'h36;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;

  // 50MHz clock: 20ns per cycle
  localparam int DEF_SETUP_CYC = 10;     // 200ns
  localparam int DEF_EN_CYC    = 25;     // 500ns
  localparam int DEF_EXEC_CYC  = 3600;   // 72us
  localparam int DEF_CLR_CYC   = 80000;  // 1.6ms
  localparam int DEF_CNT_W     = 17;

  // Display clear is a command (rs=0) with byte 8'h01 and executes far slower.
  function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data == CMD_CLEAR);
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// -----------------------------------------------------------------------------
// lcd_rr_arb
// Two-way round-robin selection with an owner lock.
//   clk, rst    : clock, synchronous active-low reset
//   sel_en      : the bus is idle and may be (re)assigned this cycle
//   req         : per-port request
//   req_lock    : per-port lock; honoured only for the current owner
//   grant_cur   : current one-hot owner (0 = unowned)
//   grant_nxt   : owner to load when sel_en is high
//   start       : a byte transfer begins for grant_nxt when sel_en is high
// The only state is the last-served pointer; everything else is combinational.
// -----------------------------------------------------------------------------
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_en,
  input  logic [1:0] req,
  input  logic [1:0] req_lock,
  input  logic [1:0] grant_cur,
  output logic [1:0] grant_nxt,
  output logic       start
);

  logic last_q, last_d;

  always_comb begin
    grant_nxt = 2'b00;
    start     = 1'b0;
    if ((grant_cur != 2'b00) && ((grant_cur & req_lock) != 2'b00)) begin
      // Locked owner keeps the bus even with no request pending, so a
      // multi-byte sequence with gaps cannot be interleaved.
      grant_nxt = grant_cur;
      start     = (grant_cur & req) != 2'b00;
    end else if (req == 2'b11) begin
      grant_nxt = last_q ? 2'b01 : 2'b10;
      start     = 1'b1;
    end else if (req[0]) begin
      grant_nxt = 2'b01;
      start     = 1'b1;
    end else if (req[1]) begin
      grant_nxt = 2'b10;
      start     = 1'b1;
    end
  end

  always_comb begin
    last_d = last_q;
    if (sel_en && start) begin
      last_d = grant_nxt[1];
    end
  end

  // last=1 after reset so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_bus_arbiter
// Owns the ST7920 parallel bus and shares it between two byte requesters,
// generating the write strobe timing directly from the system clock.
//   clk, rst  : 50MHz clock, synchronous active-low reset
//   req       : per-port request, held with req_rs/req_data until ack
//   req_lock  : per-port lock; the granted port keeps the bus while set
//   req_rs    : per-port register select (0 command, 1 data)
//   req_data  : per-port byte, port0 [7:0], port1 [15:8]
//   ack       : one-cycle pulse, byte written and execution wait finished
//   grant     : one-hot current owner, 0 when unowned
//   busy      : a write cycle is in progress
//   rs/rw/en/data : LCD bus (rw fixed at 0, write only)
// -----------------------------------------------------------------------------
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC,
  parameter int EXEC_CYC  = DEF_EXEC_CYC,
  parameter int CLR_CYC   = DEF_CLR_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  req_lock,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  output logic [1:0]  ack,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        rs,
  output logic        rw,
  output logic        en,
  output logic [7:0]  data
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             clr_q, clr_d;
  logic             en_q, en_d;
  logic [1:0]       ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       grant_nxt;
  logic             start;
  logic             sel_en;
  logic [CNT_W-1:0] wait_last;
  logic [7:0]       port_byte [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign port_byte[gi] = req_data[gi*8 +: 8];
  end

  // The two cycles after DONE (registering done, then ack) keep the bus
  // closed, so a requester sees its ack and gets a full cycle to drop req
  // before IDLE samples the requests again.
  assign sel_en    = (state_q == ST_IDLE) && !done_q && (ack_q == 2'b00);
  assign wait_last = clr_q ? CLR_LAST : EXEC_LAST;

  lcd_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .sel_en    (sel_en),
    .req       (req),
    .req_lock  (req_lock),
    .grant_cur (grant_q),
    .grant_nxt (grant_nxt),
    .start     (start)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: every state lasts exactly its cycle count, counter restarts
  // at 0 on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sel_en && start) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_PULSE;
          cnt_d   = '0;
        end
      end
      ST_PULSE: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs and latched byte; the byte is captured only at selection so
  // req_* changes mid-transfer never reach the bus.
  always_comb begin
    grant_d = grant_q;
    rs_d    = rs_q;
    data_d  = data_q;
    clr_d   = clr_q;
    if (sel_en) begin
      grant_d = grant_nxt;
      if (start) begin
        rs_d   = grant_nxt[1] ? req_rs[1] : req_rs[0];
        data_d = grant_nxt[1] ? port_byte[1] : port_byte[0];
        clr_d  = is_clear_cmd(rs_d, data_d);
      end
    end
    en_d   = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
    ack_d  = done_q ? grant_q : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q <= 2'b00;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 2'b00;
    end else begin
      grant_q <= grant_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  assign ack   = ack_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign rs    = rs_q;
  assign rw    = 1'b0;
  assign en    = en_q;
  assign data  = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
module tb_lcd_bus_arbiter;

  localparam int SETUP  = 10;
  localparam int ENC    = 25;
  localparam int EXEC   = 200;
  localparam int CLR    = 900;
  localparam int BUDGET = SETUP + ENC + CLR + 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_lock = 2'b00;
  logic [1:0]  req_rs = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  ack, grant;
  logic        busy, rs, rw, en;
  logic [7:0]  data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: who was served last and who currently owns the bus.
  int model_last  = 1;
  int model_owner = -1;

  lcd_bus_arbiter #(
    .SETUP_CYC (SETUP),
    .EN_CYC    (ENC),
    .EXEC_CYC  (EXEC),
    .CLR_CYC   (CLR),
    .CNT_W     (17)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_lock (req_lock),
    .req_rs   (req_rs),
    .req_data (req_data),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy),
    .rs       (rs),
    .rw       (rw),
    .en       (en),
    .data     (data)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] onehot(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  // Spec-level selection rule
  function automatic int model_pick(input logic [1:0] r, input logic [1:0] lk);
    if (model_owner >= 0 && lk[model_owner]) return r[model_owner] ? model_owner : -1;
    if (r == 2'b11) return 1 - model_last;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  // Waits for the next selection, then follows the whole write cycle.
  task automatic xfer(input int port, input string tag, input bit mutate);
    logic       exp_rs;
    logic [7:0] exp_data;
    int wait_c, t_sel, t_rise, t_fall, k;
    bit unstable;
    exp_rs   = req_rs[port];
    exp_data = req_data[port*8 +: 8];
    wait_c   = (exp_rs == 1'b0 && exp_data == 8'h01) ? CLR : EXEC;
    k = 0;
    while (!busy && k < BUDGET) begin
      tick();
      k++;
    end
    check({tag, "_select"}, 32'(busy), 32'd1);
    if (!busy) return;
    t_sel = cyc;
    check({tag, "_grant"}, 32'(grant), 32'(onehot(port)));
    check({tag, "_data"}, 32'(data), 32'(exp_data));
    check({tag, "_rs"}, 32'(rs), 32'(exp_rs));
    model_last  = port;
    model_owner = port;
    t_rise = -1;
    t_fall = -1;
    unstable = 1'b0;
    k = 0;
    while (ack == 2'b00 && k < BUDGET) begin
      tick();
      k++;
      if (en && t_rise < 0) t_rise = cyc;
      if (!en && t_rise >= 0 && t_fall < 0) begin
        t_fall = cyc;
        if (mutate) begin
          req_data = ~req_data;
          req_rs   = ~req_rs;
        end
      end
      if (busy && (data !== exp_data || rs !== exp_rs || rw !== 1'b0)) unstable = 1'b1;
    end
    check({tag, "_en_rise"}, 32'(t_rise - t_sel), 32'(SETUP));
    check({tag, "_en_width"}, 32'(t_fall - t_rise), 32'(ENC));
    check({tag, "_ack_latency"}, 32'(cyc - t_sel), 32'(SETUP + ENC + wait_c + 2));
    check({tag, "_ack_port"}, 32'(ack), 32'(onehot(port)));
    check({tag, "_bus_stable"}, 32'(unstable), 32'd0);
    $display("[TB] xfer %s port=%0d rs=%0d data=%02h latency=%0d", tag, port, exp_rs, exp_data,
             cyc - t_sel);
  endtask

  task automatic release_check(input string tag);
    repeat (3) tick();
    check({tag, "_release"}, 32'(grant), 32'd0);
    model_owner = -1;
  endtask

  initial begin
    logic [7:0] lock_bytes [3];
    int p, k;
    lock_bytes[0] = 8'h80;
    lock_bytes[1] = 8'h90;
    lock_bytes[2] = 8'hFF;

    // Reset state
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_rs", 32'(rs), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    rst = 1'b1;
    tick();

    // 1: port0 basic command
    req_rs[0] = 1'b0;
    req_data[7:0] = 8'h30;
    req = 2'b01;
    xfer(0, "t1", 1'b0);
    req = 2'b00;
    release_check("t1");

    // 2: clear command on port1 takes the long wait
    req_rs[1] = 1'b0;
    req_data[15:8] = 8'h01;
    req = 2'b10;
    xfer(1, "t2_clear", 1'b0);
    req = 2'b00;
    release_check("t2");

    // 3: continuous contention alternates
    req_rs = 2'b11;
    req_data = 16'h55AA;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      p = model_pick(req, req_lock);
      check("t3_alternate", 32'(p), 32'(i % 2));
      xfer(p, "t3", 1'b0);
    end
    req = 2'b00;
    release_check("t3");

    // 4: port0 lock across three bytes with gaps
    req_lock = 2'b01;
    req_rs = 2'b11;
    req_data[15:8] = 8'h33;
    req[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data[7:0] = lock_bytes[i];
      req[0] = 1'b1;
      p = model_pick(req, req_lock);
      xfer(p, "t4_lock", 1'b0);
      check("t4_owner", 32'(p), 32'd0);
      req[0] = 1'b0;
      repeat (5) tick();
      check("t4_gap_grant", 32'(grant), 32'd1);
      check("t4_gap_busy", 32'(busy), 32'd0);
    end
    req_lock = 2'b00;
    p = model_pick(req, req_lock);
    xfer(p, "t4_after", 1'b0);
    check("t4_after_port", 32'(p), 32'd1);
    req = 2'b00;
    release_check("t4");

    // 5: reset during the enable pulse
    req_rs[0] = 1'b1;
    req_data[7:0] = 8'h42;
    req = 2'b01;
    k = 0;
    while (!en && k < BUDGET) begin
      tick();
      k++;
    end
    check("t5_en_seen", 32'(en), 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("t5_en", 32'(en), 32'd0);
    check("t5_ack", 32'(ack), 32'd0);
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    req = 2'b00;
    tick();
    rst = 1'b1;
    model_last  = 1;
    model_owner = -1;
    req_data = 16'h2211;
    req_rs = 2'b11;
    req = 2'b11;
    p = model_pick(req, req_lock);
    xfer(p, "t5_first", 1'b0);
    check("t5_first_port", 32'(p), 32'd0);
    req = 2'b00;
    release_check("t5");

    // 6: req_data/req_rs change during WAIT
    req_rs[1] = 1'b1;
    req_data[15:8] = 8'h5A;
    req = 2'b10;
    xfer(1, "t6_mutate", 1'b1);
    req = 2'b00;
    release_check("t6");

    // Random traffic against the model
    for (int i = 0; i < 8; i++) begin
      for (int q = 0; q < 2; q++) begin
        if ($urandom_range(0, 3) == 0) begin
          req_rs[q] = 1'b0;
          req_data[q*8 +: 8] = 8'h01;
        end else begin
          req_rs[q] = 1'($urandom_range(0, 1));
          req_data[q*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
      req = 2'($urandom_range(1, 3));
      p = model_pick(req, req_lock);
      xfer(p, "rnd", 1'b0);
      req = 2'b00;
      release_check("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
